// File: rtl/baby_ram_arbiter.sv
// baby_ram_arbiter: arbitrates a core and a host requester onto one single-port RAM.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration. Without it,
// fixed priority applies and host wins over core.
// Ports:
//   clock, reset_i             rising-edge clock, synchronous active-high reset
//   core_req_i/core_we_i/...   core requester: level req held until the one-cycle ack;
//                              we/addr/wdata are sampled at grant; rdata is held until
//                              the next read of that requester completes
//   host_req_i/host_we_i/...   host requester, same meaning as the core ports
//   ram_addr_o, ram_data_o     RAM address and write data, latched at grant
//   ram_data_i                 RAM read data, captured on the last read ACCESS cycle
//   ram_rw_en_o                single-cycle write strobe (0 = read)
module baby_ram_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_ack_o,
    output logic [DATA_W-1:0] core_rdata_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_ack_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              ram_rw_en_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [1:0] LAST_CNT = 2'(RAM_LAT - 1);
    state_t            r_state, w_next;
    logic [1:0]        r_cnt;
    logic              r_we, r_win_host;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_core_rdata, r_host_rdata;
    logic              w_any, w_grant, w_grant_host, w_read_last;

    assign w_any       = core_req_i | host_req_i;
    assign w_grant     = (r_state == IDLE) & w_any;
    // A read ends when the latency counter reaches its last cycle.
    assign w_read_last = (r_state == ACCESS) & ~r_we & (r_cnt == LAST_CNT);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_host;
    // On a tie, the requester that did not win last time gets the RAM.
    assign w_grant_host = host_req_i & (~core_req_i | ~r_last_host);
    always_ff @(posedge clock) begin
        if (reset_i)
            r_last_host <= 1'b1;
        else if (w_grant)
            r_last_host <= w_grant_host;
    end
`else
    assign w_grant_host = host_req_i;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ACCESS : IDLE;
            ACCESS:  w_next = (r_we | w_read_last) ? DONE : ACCESS;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_cnt        <= 2'd0;
            r_we         <= 1'b0;
            r_win_host   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_rdata <= '0;
            r_host_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_win_host <= w_grant_host;
                r_we       <= w_grant_host ? host_we_i    : core_we_i;
                r_addr     <= w_grant_host ? host_addr_i  : core_addr_i;
                r_wdata    <= w_grant_host ? host_wdata_i : core_wdata_i;
            end
            if (r_state == ACCESS && !r_we)
                r_cnt <= w_read_last ? 2'd0 : r_cnt + 2'd1;
            if (w_read_last && r_win_host)
                r_host_rdata <= ram_data_i;
            if (w_read_last && !r_win_host)
                r_core_rdata <= ram_data_i;
        end
    end

    assign ram_rw_en_o  = (r_state == ACCESS) & r_we;
    assign core_ack_o   = (r_state == DONE) & ~r_win_host;
    assign host_ack_o   = (r_state == DONE) & r_win_host;
    assign ram_addr_o   = r_addr;
    assign ram_data_o   = r_wdata;
    assign core_rdata_o = r_core_rdata;
    assign host_rdata_o = r_host_rdata;
endmodule

// File: tb/tb_baby_ram_arbiter.sv
// tb_baby_ram_arbiter: directed self-checking bench for baby_ram_arbiter (RAM_LAT 1 and 3).
module tb_baby_ram_arbiter;
    logic        clock = 1'b0;
    logic        reset_i, core_req, core_we, host_req, host_we;
    logic [4:0]  core_addr, host_addr;
    logic [31:0] core_wdata, host_wdata;
    logic        d1_core_ack, d1_host_ack, d1_rw_en, d3_core_ack, d3_host_ack, d3_rw_en;
    logic [31:0] d1_core_rdata, d1_host_rdata, d1_ram_data, d1_ram_rd;
    logic [31:0] d3_core_rdata, d3_host_rdata, d3_ram_data, d3_ram_rd;
    logic [4:0]  d1_ram_addr, d3_ram_addr;
    logic [31:0] mem [32];
    logic        prev_rw = 1'b0;
    int          checks = 0;
    int          failures = 0;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clock = ~clock;

    assign d1_ram_rd = mem[d1_ram_addr];
    assign d3_ram_rd = mem[d3_ram_addr];

    baby_ram_arbiter #(.ADDR_W(5), .DATA_W(32), .RAM_LAT(1)) u_dut1 (
        .clock(clock), .reset_i(reset_i),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_ack_o(d1_core_ack), .core_rdata_o(d1_core_rdata),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_ack_o(d1_host_ack), .host_rdata_o(d1_host_rdata),
        .ram_addr_o(d1_ram_addr), .ram_data_o(d1_ram_data), .ram_data_i(d1_ram_rd), .ram_rw_en_o(d1_rw_en)
    );

    baby_ram_arbiter #(.ADDR_W(5), .DATA_W(32), .RAM_LAT(3)) u_dut3 (
        .clock(clock), .reset_i(reset_i),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_ack_o(d3_core_ack), .core_rdata_o(d3_core_rdata),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_ack_o(d3_host_ack), .host_rdata_o(d3_host_rdata),
        .ram_addr_o(d3_ram_addr), .ram_data_o(d3_ram_data), .ram_data_i(d3_ram_rd), .ram_rw_en_o(d3_rw_en)
    );

    // Protocol invariants on the RAM_LAT=1 instance: no two-cycle write strobe, no double ack.
    always @(negedge clock) begin
        if (!reset_i) begin
            checks++;
            if (d1_rw_en === 1'b1 && prev_rw === 1'b1) begin
                failures++;
                $display("FAIL rw_en_consecutive got=11 exp=not_11 t=%0t", $time);
            end
            checks++;
            if ((d1_core_ack & d1_host_ack) !== 1'b0) begin
                failures++;
                $display("FAIL double_ack got=%b%b exp=not_11 t=%0t", d1_core_ack, d1_host_ack, $time);
            end
        end
        prev_rw = d1_rw_en;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        reset_i = 1;
        tick();
        tick();
        reset_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (d1_core_ack !== 1'b0) begin failures++; $display("FAIL rst_core_ack got=%b exp=0", d1_core_ack); end
        checks++; if (d1_host_ack !== 1'b0) begin failures++; $display("FAIL rst_host_ack got=%b exp=0", d1_host_ack); end
        checks++; if (d1_rw_en !== 1'b0) begin failures++; $display("FAIL rst_rw_en got=%b exp=0", d1_rw_en); end
        checks++; if (d1_ram_addr !== 5'h00) begin failures++; $display("FAIL rst_ram_addr got=%h exp=00", d1_ram_addr); end
        checks++; if (d1_ram_data !== 32'h0) begin failures++; $display("FAIL rst_ram_data got=%h exp=0", d1_ram_data); end
        checks++; if (d1_core_rdata !== 32'h0) begin failures++; $display("FAIL rst_core_rdata got=%h exp=0", d1_core_rdata); end
        checks++; if (d1_host_rdata !== 32'h0) begin failures++; $display("FAIL rst_host_rdata got=%h exp=0", d1_host_rdata); end
        checks++; if (d3_rw_en !== 1'b0) begin failures++; $display("FAIL rst_d3_rw_en got=%b exp=0", d3_rw_en); end
    endtask

    task automatic test_core_write();
        do_reset();
        core_req = 1; core_we = 1; core_addr = 5'h03; core_wdata = 32'hDEADBEEF;
        checks++; if (d1_rw_en !== 1'b0) begin failures++; $display("FAIL wr_c0_rw_en got=%b exp=0", d1_rw_en); end
        tick();
        core_addr = 5'h0A; core_wdata = 32'h0;
        checks++; if (d1_rw_en !== 1'b1) begin failures++; $display("FAIL wr_c1_rw_en got=%b exp=1", d1_rw_en); end
        checks++; if (d1_ram_addr !== 5'h03) begin failures++; $display("FAIL wr_c1_addr got=%h exp=03", d1_ram_addr); end
        checks++; if (d1_ram_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_c1_data got=%h exp=deadbeef", d1_ram_data); end
        checks++; if (d1_core_ack !== 1'b0) begin failures++; $display("FAIL wr_c1_ack got=%b exp=0", d1_core_ack); end
        tick();
        checks++; if (d1_rw_en !== 1'b0) begin failures++; $display("FAIL wr_c2_rw_en got=%b exp=0", d1_rw_en); end
        checks++; if (d1_core_ack !== 1'b1) begin failures++; $display("FAIL wr_c2_core_ack got=%b exp=1", d1_core_ack); end
        checks++; if (d1_host_ack !== 1'b0) begin failures++; $display("FAIL wr_c2_host_ack got=%b exp=0", d1_host_ack); end
        checks++; if (d3_core_ack !== 1'b1) begin failures++; $display("FAIL wr_c2_d3_ack got=%b exp=1", d3_core_ack); end
        tick();
        core_req = 0;
        checks++; if (d1_core_ack !== 1'b0) begin failures++; $display("FAIL wr_c3_ack got=%b exp=0", d1_core_ack); end
        checks++; if (d1_ram_addr !== 5'h03) begin failures++; $display("FAIL wr_c3_addr_hold got=%h exp=03", d1_ram_addr); end
        checks++; if (d1_ram_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_c3_data_hold got=%h exp=deadbeef", d1_ram_data); end
        tick();
    endtask

    task automatic test_host_read();
        do_reset();
        host_req = 1; host_we = 0; host_addr = 5'h1F;
        for (int c = 0; c <= 4; c++) begin
            checks++; if (d3_rw_en !== 1'b0) begin failures++; $display("FAIL rd3_rw_en c%0d got=%b exp=0", c, d3_rw_en); end
            checks++; if (d3_host_ack !== (c == 4)) begin failures++; $display("FAIL rd3_host_ack c%0d got=%b exp=%b", c, d3_host_ack, c == 4); end
            checks++; if (d1_host_ack !== (c == 2)) begin failures++; $display("FAIL rd1_host_ack c%0d got=%b exp=%b", c, d1_host_ack, c == 2); end
            if (c < 4) tick();
        end
        checks++; if (d3_host_rdata !== 32'h12345678) begin failures++; $display("FAIL rd3_rdata got=%h exp=12345678", d3_host_rdata); end
        checks++; if (d3_core_ack !== 1'b0) begin failures++; $display("FAIL rd3_core_ack got=%b exp=0", d3_core_ack); end
        checks++; if (d1_host_rdata !== 32'h12345678) begin failures++; $display("FAIL rd1_rdata got=%h exp=12345678", d1_host_rdata); end
        tick();
        host_req = 0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic exp_h, exp_c;
        do_reset();
        core_req = 1; host_req = 1; core_we = 0; host_we = 0; core_addr = 5'h00; host_addr = 5'h01;
        for (int c = 0; c <= 6; c++) begin
            if (c == 3) begin if (RR) core_req = 0; else host_req = 0; end
            if (c == 6) begin if (RR) host_req = 0; else core_req = 0; end
            exp_h = RR ? (c == 5) : (c == 2);
            exp_c = RR ? (c == 2) : (c == 5);
            checks++; if (d1_host_ack !== exp_h) begin failures++; $display("FAIL sim_host_ack c%0d got=%b exp=%b", c, d1_host_ack, exp_h); end
            checks++; if (d1_core_ack !== exp_c) begin failures++; $display("FAIL sim_core_ack c%0d got=%b exp=%b", c, d1_core_ack, exp_c); end
            if (c < 6) tick();
        end
        checks++; if (d1_core_rdata !== 32'hA5A50000) begin failures++; $display("FAIL sim_core_rdata got=%h exp=a5a50000", d1_core_rdata); end
        checks++; if (d1_host_rdata !== 32'hA5A50001) begin failures++; $display("FAIL sim_host_rdata got=%h exp=a5a50001", d1_host_rdata); end
        tick();
    endtask

    task automatic test_alternate();
        logic exp_h, exp_c;
        do_reset();
        core_req = 1; host_req = 1; core_we = 0; host_we = 0; core_addr = 5'h00; host_addr = 5'h01;
        for (int c = 0; c <= 11; c++) begin
            exp_h = (c % 3 == 2) && (!RR || ((c / 3) % 2 == 1));
            exp_c = (c % 3 == 2) && !exp_h;
            checks++; if (d1_host_ack !== exp_h) begin failures++; $display("FAIL alt_host_ack c%0d got=%b exp=%b", c, d1_host_ack, exp_h); end
            checks++; if (d1_core_ack !== exp_c) begin failures++; $display("FAIL alt_core_ack c%0d got=%b exp=%b", c, d1_core_ack, exp_c); end
            if (c < 11) tick();
        end
        core_req = 0; host_req = 0;
        tick();
    endtask

    task automatic test_reset_abort();
        do_reset();
        core_req = 1; core_we = 1; core_addr = 5'h03; core_wdata = 32'hCAFEF00D;
        tick();
        checks++; if (d1_rw_en !== 1'b1) begin failures++; $display("FAIL abort_c1_rw_en got=%b exp=1", d1_rw_en); end
        reset_i = 1;
        tick();
        reset_i = 0; core_req = 0;
        checks++; if (d1_core_ack !== 1'b0) begin failures++; $display("FAIL abort_c2_core_ack got=%b exp=0", d1_core_ack); end
        checks++; if (d1_host_ack !== 1'b0) begin failures++; $display("FAIL abort_c2_host_ack got=%b exp=0", d1_host_ack); end
        checks++; if (d1_rw_en !== 1'b0) begin failures++; $display("FAIL abort_c2_rw_en got=%b exp=0", d1_rw_en); end
        checks++; if (d1_ram_addr !== 5'h00) begin failures++; $display("FAIL abort_c2_addr got=%h exp=00", d1_ram_addr); end
        checks++; if (d1_ram_data !== 32'h0) begin failures++; $display("FAIL abort_c2_data got=%h exp=0", d1_ram_data); end
        tick();
        checks++; if (d1_core_ack !== 1'b0) begin failures++; $display("FAIL abort_c3_core_ack got=%b exp=0", d1_core_ack); end
        host_req = 1; host_we = 1; host_addr = 5'h05; host_wdata = 32'h00000055;
        tick();
        checks++; if (d1_rw_en !== 1'b1) begin failures++; $display("FAIL abort_new_rw_en got=%b exp=1", d1_rw_en); end
        checks++; if (d1_ram_addr !== 5'h05) begin failures++; $display("FAIL abort_new_addr got=%h exp=05", d1_ram_addr); end
        tick();
        checks++; if (d1_host_ack !== 1'b1) begin failures++; $display("FAIL abort_new_host_ack got=%b exp=1", d1_host_ack); end
        tick();
        host_req = 0;
        tick();
    endtask

    task automatic test_req_through_reset();
        core_req = 0; host_req = 1; host_we = 0; host_addr = 5'h1F;
        reset_i = 1;
        tick();
        tick();
        reset_i = 0;
        tick();
        checks++; if (d1_host_ack !== 1'b0) begin failures++; $display("FAIL rtr_c1_ack got=%b exp=0", d1_host_ack); end
        tick();
        checks++; if (d1_host_ack !== 1'b1) begin failures++; $display("FAIL rtr_c2_ack got=%b exp=1", d1_host_ack); end
        checks++; if (d1_host_rdata !== 32'h12345678) begin failures++; $display("FAIL rtr_rdata got=%h exp=12345678", d1_host_rdata); end
        tick();
        host_req = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd;
        do_reset();
        core_req = 1; core_we = 0; core_addr = 5'h00;
        for (int c = 0; c <= 5; c++) begin
            if (c == 1) core_addr = 5'h07;
            if (c == 3) core_addr = 5'h01;
            exp_rd = (c >= 5) ? 32'hA5A50001 : 32'hA5A50000;
            checks++; if (d1_core_ack !== (c == 2 || c == 5)) begin failures++; $display("FAIL b2b_ack c%0d got=%b exp=%b", c, d1_core_ack, c == 2 || c == 5); end
            checks++; if (d1_rw_en !== 1'b0) begin failures++; $display("FAIL b2b_rw_en c%0d got=%b exp=0", c, d1_rw_en); end
            if (c >= 2) begin
                checks++; if (d1_core_rdata !== exp_rd) begin failures++; $display("FAIL b2b_rdata c%0d got=%h exp=%h", c, d1_core_rdata, exp_rd); end
            end
            if (c < 5) tick();
        end
        tick();
        core_req = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA5A50000 + 32'(i);
        mem[31] = 32'h12345678;
        test_reset();
        test_core_write();
        test_host_read();
        test_simultaneous();
        test_alternate();
        test_reset_abort();
        test_req_through_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
